// File: rtl/fetch_unit.sv
// Instruction-fetch front end.
// Owns the PC and issues in-order fetch requests to instruction memory.
// Returned words are held in a small prefetch FIFO that feeds decode through a valid/ready port.
// A redirect (taken branch/jump) flushes the FIFO and discards every fetch still in flight.
//
// Handshake semantics, for every valid/ready pair on this block:
//   a transfer happens on a rising edge where valid && ready;
//   a producer never withdraws valid or changes its payload while valid && !ready, except on redirect or reset.
module fetch_unit #(
  parameter int               WIDTH    = 32,
  parameter int               DEPTH    = 4,
  parameter logic [WIDTH-1:0] RESET_PC = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc
);

  localparam int AW = $clog2(DEPTH);  // FIFO pointer width
  localparam int CW = AW + 1;         // holds 0..DEPTH
  localparam int DW = AW + 2;         // holds 0..2*DEPTH

  // Architectural state
  logic [WIDTH-1:0] r_pc;           // address of the next request to issue
  logic [WIDTH-1:0] r_rsp_pc;       // PC belonging to the next kept response
  logic [CW-1:0]    r_count;        // FIFO occupancy
  logic [CW-1:0]    r_outstanding;  // accepted requests on the current path, not yet returned
  logic [DW-1:0]    r_drop;         // responses still owed from flushed paths
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [WIDTH-1:0] r_fifo_data [DEPTH];
  logic [WIDTH-1:0] r_fifo_pc   [DEPTH];

  // Datapath and handshake wires
  logic [DW-1:0]    w_credit_sum;
  logic             w_has_credit;
  logic             w_req_fire;
  logic             w_rsp_discard;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_redirect_target;
  logic             w_unused;

  // Low two bits of the redirect target are architecturally ignored.
  assign w_unused          = ^redirect_pc[1:0];
  assign w_redirect_target = {redirect_pc[WIDTH-1:2], 2'b00};

  // Buffered plus in-flight fetches may never exceed the FIFO size, so a push always finds room.
  // Responses owed to flushed paths are not counted: they never enter the FIFO.
  assign w_credit_sum  = DW'(r_count) + DW'(r_outstanding);
  assign w_has_credit  = (w_credit_sum < DW'(DEPTH));

  assign imem_req_valid = rst && !redirect_valid && w_has_credit;
  assign imem_addr      = r_pc;
  assign w_req_fire     = imem_req_valid && imem_req_ready;

  // Responses come back in order, so the first r_drop of them belong to flushed paths.
  assign w_rsp_discard = imem_rsp_valid && (r_drop != '0);
  assign w_push        = imem_rsp_valid && (r_drop == '0) && !redirect_valid;

  assign instr_valid = (r_count != '0) && !redirect_valid;
  assign instr       = r_fifo_data[r_rd_ptr];
  assign instr_pc    = r_fifo_pc[r_rd_ptr];
  assign w_pop       = instr_valid && instr_ready;

  // PC, response-PC, occupancy, credit and drop bookkeeping; a redirect overrides everything else.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_pc          <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_count       <= '0;
      r_outstanding <= '0;
      r_drop        <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
    end else if (redirect_valid) begin
      r_pc          <= w_redirect_target;
      r_rsp_pc      <= w_redirect_target;
      r_count       <= '0;
      r_wr_ptr      <= '0;
      r_rd_ptr      <= '0;
      r_outstanding <= '0;
      // Everything in flight is now stale; a response arriving this cycle settles one of them.
      r_drop        <= r_drop + DW'(r_outstanding) - DW'(imem_rsp_valid);
    end else begin
      if (w_req_fire) begin
        r_pc <= r_pc + WIDTH'(4);
      end
      if (w_push) begin
        r_rsp_pc <= r_rsp_pc + WIDTH'(4);
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + AW'(1);
      end
      if (w_rsp_discard) begin
        r_drop <= r_drop - DW'(1);
      end
      r_count       <= r_count + CW'(w_push) - CW'(w_pop);
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(w_push);
    end
  end

  // FIFO storage; cleared on reset so the head reads as zero until the first push.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        r_fifo_data[i] <= '0;
        r_fifo_pc[i]   <= '0;
      end
    end else if (w_push) begin
      r_fifo_data[r_wr_ptr] <= imem_rsp_data;
      r_fifo_pc[r_wr_ptr]   <= r_rsp_pc;
    end
  end

  // A push into a full FIFO means the request credit was bypassed.
  a_no_overflow: assert property (@(posedge clk) disable iff (!rst)
    w_push |-> (r_count < CW'(DEPTH)));

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit.
// A latency-programmable instruction memory answers requests in order with data = addr >> 2.
// The reference model tags each request with the path (epoch) it was issued on.
// Decode must see exactly the current path's addresses, in order, with nothing from a flushed path.
module tb_fetch_unit;
  localparam int W     = 32;
  localparam int DEPTH = 4;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         redirect_valid = 1'b0;
  logic [W-1:0] redirect_pc = '0;
  logic         imem_req_valid;
  logic         imem_req_ready = 1'b0;
  logic [W-1:0] imem_addr;
  logic         imem_rsp_valid = 1'b0;
  logic [W-1:0] imem_rsp_data = '0;
  logic         instr_valid;
  logic         instr_ready = 1'b0;
  logic [W-1:0] instr;
  logic [W-1:0] instr_pc;

  fetch_unit #(.WIDTH(W), .DEPTH(DEPTH), .RESET_PC('0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- scoreboard state ----------------
  typedef struct {
    logic [W-1:0] addr;
    int           epoch;
    int           due;
  } mreq_t;

  int           errors = 0;
  int           checks = 0;
  mreq_t        mem_q[$];
  mreq_t        m;
  logic [W-1:0] exp_q[$];
  logic [W-1:0] pop_log[$];
  logic [W-1:0] e;
  int           cyc = 0;
  int           last_due = 0;
  int           epoch = 0;
  int           in_cur = 0;
  int           lat_min = 1;
  int           lat_max = 1;
  int           fire_cnt = 0;
  int           pop_cnt = 0;
  int           due;
  logic [W-1:0] exp_req_addr = '0;
  logic         rsp_now = 1'b0;
  logic [W-1:0] rsp_addr = '0;
  int           rsp_epoch = 0;
  logic         fire, pop, exp_v, exp_iv;
  logic         prev_req_stall = 1'b0;
  logic         prev_instr_hold = 1'b0;
  logic [W-1:0] prev_addr, prev_instr, prev_ipc;

  // Memory model plus per-cycle scoreboard.
  // Inputs change on the falling edge; 1 time unit later the sampled values are
  // exactly those the DUT registers on the next rising edge.
  always begin
    @(negedge clk);
    cyc++;
    rsp_now = 1'b0;
    if (!rst) begin
      mem_q.delete();
    end else if (mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      m         = mem_q.pop_front();
      rsp_now   = 1'b1;
      rsp_addr  = m.addr;
      rsp_epoch = m.epoch;
    end
    imem_rsp_valid = rsp_now;
    imem_rsp_data  = rsp_now ? (rsp_addr >> 2) : $urandom;
    #1;
    if (!rst) begin
      exp_q.delete();
      in_cur          = 0;
      epoch++;
      last_due        = cyc;
      exp_req_addr    = '0;
      prev_req_stall  = 1'b0;
      prev_instr_hold = 1'b0;
    end else begin
      fire = imem_req_valid && imem_req_ready;
      pop  = instr_valid && instr_ready;
      // Request valid iff not redirecting and current-path fetches not yet consumed < DEPTH.
      exp_v = !redirect_valid && ((in_cur + exp_q.size()) < DEPTH);
      checks++;
      if (imem_req_valid !== exp_v) begin
        errors++;
        $display("FAIL req_valid cyc=%0d: got %b expected %b", cyc, imem_req_valid, exp_v);
      end
      if (fire) begin
        checks++;
        if (imem_addr !== exp_req_addr) begin
          errors++;
          $display("FAIL req_addr cyc=%0d: got %h expected %h", cyc, imem_addr, exp_req_addr);
        end
        exp_req_addr = exp_req_addr + 32'd4;
      end
      if (prev_req_stall && !redirect_valid) begin
        checks++;
        if (imem_req_valid !== 1'b1 || imem_addr !== prev_addr) begin
          errors++;
          $display("FAIL req_stable cyc=%0d: got v=%b a=%h expected v=1 a=%h", cyc, imem_req_valid, imem_addr, prev_addr);
        end
      end
      exp_iv = !redirect_valid && (exp_q.size() > 0);
      checks++;
      if (instr_valid !== exp_iv) begin
        errors++;
        $display("FAIL instr_valid cyc=%0d: got %b expected %b", cyc, instr_valid, exp_iv);
      end
      if (prev_instr_hold && !redirect_valid) begin
        checks++;
        if (instr !== prev_instr || instr_pc !== prev_ipc) begin
          errors++;
          $display("FAIL instr_stable cyc=%0d: got %h/%h expected %h/%h", cyc, instr, instr_pc, prev_instr, prev_ipc);
        end
      end
      if (pop && exp_q.size() > 0) begin
        e = exp_q.pop_front();
        checks++;
        if (instr_pc !== e || instr !== (e >> 2)) begin
          errors++;
          $display("FAIL instr_data cyc=%0d: got pc=%h i=%h expected pc=%h i=%h", cyc, instr_pc, instr, e, e >> 2);
        end
        pop_cnt++;
        pop_log.push_back(instr_pc);
      end
      if (rsp_now && rsp_epoch == epoch && !redirect_valid) begin
        exp_q.push_back(rsp_addr);
        in_cur--;
      end
      if (fire) begin
        due = cyc + $urandom_range(lat_min, lat_max);
        if (due <= last_due) due = last_due + 1;
        last_due = due;
        mem_q.push_back('{addr: imem_addr, epoch: epoch, due: due});
        in_cur++;
        fire_cnt++;
      end
      if (redirect_valid) begin
        epoch++;
        exp_q.delete();
        in_cur          = 0;
        exp_req_addr    = {redirect_pc[W-1:2], 2'b00};
        prev_req_stall  = 1'b0;
        prev_instr_hold = 1'b0;
      end else begin
        prev_req_stall  = imem_req_valid && !imem_req_ready;
        prev_addr       = imem_addr;
        prev_instr_hold = instr_valid && !instr_ready;
        prev_instr      = instr;
        prev_ipc        = instr_pc;
      end
    end
  end

  // ---------------- driver tasks ----------------
  // Ends on a falling edge with reset still asserted; the caller releases it there (cycle 0).
  task automatic hold_reset();
    @(negedge clk);
    rst            = 1'b0;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    imem_req_ready = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    imem_req_ready = 1'b1; instr_ready = 1'b1;
    repeat (2) @(negedge clk);
    #2;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL reset_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL reset_addr: got %h expected 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL reset_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0) begin errors++; $display("FAIL reset_instr: got %h expected 0", instr); end
    checks++; if (instr_pc !== 32'h0) begin errors++; $display("FAIL reset_instr_pc: got %h expected 0", instr_pc); end
  endtask

  // L=1, decode always ready: first instruction two cycles after the first accepted request, then 1/cycle.
  task automatic test_stream();
    int first;
    int p0;
    lat_min = 1; lat_max = 1;
    hold_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rst = 1'b1;
    first = -1;
    for (int c = 0; c < 6; c++) begin
      #2;
      if (instr_valid && first < 0) first = c;
      @(negedge clk);
    end
    checks++;
    if (first != 2) begin errors++; $display("FAIL first_valid_cycle: got %0d expected 2", first); end
    p0 = pop_cnt;
    repeat (16) @(negedge clk);
    checks++;
    if (pop_cnt - p0 != 16) begin errors++; $display("FAIL stream_throughput: got %0d expected 16", pop_cnt - p0); end
  endtask

  // Decode stalled: exactly DEPTH requests accepted, then drained in order.
  task automatic test_backpressure();
    int f0;
    lat_min = 1; lat_max = 1;
    hold_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b0; rst = 1'b1;
    f0 = fire_cnt;
    repeat (10) @(negedge clk);
    #2;
    checks++;
    if (fire_cnt - f0 != DEPTH) begin errors++; $display("FAIL bp_fires: got %0d expected %0d", fire_cnt - f0, DEPTH); end
    checks++;
    if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL bp_req_valid: got %b expected 0", imem_req_valid); end
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h0) begin errors++; $display("FAIL bp_head: got v=%b pc=%h expected v=1 pc=0", instr_valid, instr_pc); end
    pop_log.delete();
    @(negedge clk);
    instr_ready = 1'b1;
    repeat (4) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (pop_log.size() <= i || pop_log[i] !== 32'(i * 4)) begin
        errors++;
        $display("FAIL bp_drain[%0d]: got %h expected %h", i, (pop_log.size() > i) ? pop_log[i] : 32'hx, 32'(i * 4));
      end
    end
  endtask

  // L=3, redirect with two fetches in flight: both stale responses vanish, new path starts at 0x100.
  task automatic test_redirect_inflight();
    int first;
    logic [W-1:0] fpc;
    lat_min = 3; lat_max = 3;
    hold_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rst = 1'b1;
    repeat (2) @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    #2;
    checks++;
    if (imem_req_valid !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL redir_cycle: got req=%b iv=%b expected 0/0", imem_req_valid, instr_valid); end
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h100) begin errors++; $display("FAIL redir_first_req: got v=%b a=%h expected v=1 a=100", imem_req_valid, imem_addr); end
    first = -1; fpc = '0;
    for (int c = 3; c < 20 && first < 0; c++) begin
      if (instr_valid) begin first = c; fpc = instr_pc; end
      @(negedge clk);
      #2;
    end
    checks++;
    if (first != 7 || fpc !== 32'h100) begin errors++; $display("FAIL redir_first_instr: got cyc=%0d pc=%h expected cyc=7 pc=100", first, fpc); end
  endtask

  // Redirect on the cycle a response lands, with unaligned target 0x203.
  task automatic test_redirect_rsp();
    lat_min = 1; lat_max = 1;
    hold_reset();
    imem_req_ready = 1'b1; instr_ready = 1'b1; rst = 1'b1;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    @(negedge clk);
    redirect_valid = 1'b0;
    #2;
    checks++;
    if (imem_req_valid !== 1'b1 || imem_addr !== 32'h200) begin errors++; $display("FAIL rr_req: got v=%b a=%h expected v=1 a=200", imem_req_valid, imem_addr); end
    @(negedge clk); #2;
    checks++;
    if (instr_valid !== 1'b0) begin errors++; $display("FAIL rr_no_stale: got %b expected 0", instr_valid); end
    @(negedge clk); #2;
    checks++;
    if (instr_valid !== 1'b1 || instr_pc !== 32'h200 || instr !== 32'h80) begin
      errors++; $display("FAIL rr_target: got v=%b pc=%h i=%h expected v=1 pc=200 i=80", instr_valid, instr_pc, instr);
    end
  endtask

  // Random stalls on both sides, random latency and random redirects.
  task automatic test_random();
    int p0;
    lat_min = 1; lat_max = 5;
    p0 = pop_cnt;
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      imem_req_ready = ($urandom_range(0, 3) != 0);
      instr_ready    = ($urandom_range(0, 3) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = $urandom;
    end
    @(negedge clk);
    redirect_valid = 1'b0; imem_req_ready = 1'b1; instr_ready = 1'b1;
    checks++;
    if (pop_cnt - p0 < 100) begin errors++; $display("FAIL random_progress: got %0d expected >=100", pop_cnt - p0); end
  endtask

  // PC wraps past 0xFFFFFFFC; then async reset in mid-burst.
  task automatic test_wrap_and_reset();
    logic seen, got, found;
    lat_min = 1; lat_max = 2;
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'hFFFF_FFF4;
    @(negedge clk);
    redirect_valid = 1'b0;
    seen = 1'b0; got = 1'b0;
    for (int c = 0; c < 30 && !got; c++) begin
      #2;
      if (imem_req_valid && imem_req_ready) begin
        if (seen) begin
          checks++;
          if (imem_addr !== 32'h0) begin errors++; $display("FAIL wrap_addr: got %h expected 0", imem_addr); end
          got = 1'b1;
        end else if (imem_addr == 32'hFFFF_FFFC) begin
          seen = 1'b1;
        end
      end
      @(negedge clk);
    end
    checks++;
    if (!got) begin errors++; $display("FAIL wrap_timeout: got none expected fetch at 0"); end
    found = 1'b0;
    for (int c = 0; c < 20 && !found; c++) begin
      @(negedge clk); #2;
      found = instr_valid;
    end
    checks++;
    if (!found) begin errors++; $display("FAIL burst_timeout: got no instr_valid expected 1"); end
    #1;
    rst = 1'b0;
    #1;
    checks++; if (imem_req_valid !== 1'b0) begin errors++; $display("FAIL async_req_valid: got %b expected 0", imem_req_valid); end
    checks++; if (imem_addr !== 32'h0) begin errors++; $display("FAIL async_addr: got %h expected 0", imem_addr); end
    checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL async_instr_valid: got %b expected 0", instr_valid); end
    checks++; if (instr !== 32'h0 || instr_pc !== 32'h0) begin errors++; $display("FAIL async_instr: got %h/%h expected 0/0", instr, instr_pc); end
    repeat (2) @(negedge clk);
    pop_log.delete();
    rst = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (pop_log.size() == 0 || pop_log[0] !== 32'h0) begin
      errors++; $display("FAIL restart_pc: got %h expected 0", (pop_log.size() > 0) ? pop_log[0] : 32'hx);
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect_inflight();
    test_redirect_rsp();
    test_random();
    test_wrap_and_reset();
    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    errors++;
    checks++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
